alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised multicycle ALU for the multicycle ARM core; successor of the single-cycle ALU.
- Add/sub/logic ops complete in one cycle. MUL/UMULL/SMULL use an iterative shift-add multiplier, one bit per cycle, instead of a combinational array.
- Start/done handshake lets the control FSM stall in its execute state. Results and NZCV flags are registered and held until the next operation.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only when busy=0.
- alu_control  in  4  operation code (see Behaviour).
- a  in  WIDTH  operand A (Rn).
- b  in  WIDTH  operand B (Rm/Src2).
- acc_lo  in  WIDTH  accumulator low (RdLo); used only with ALU_MLAL_EN.
- acc_hi  in  WIDTH  accumulator high (RdHi); used only with ALU_MLAL_EN.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: result/result_hi/alu_flags valid.
- result  out  WIDTH  result, or low half of long product.
- result_hi  out  WIDTH  high half of long product; 0 for other ops.
- alu_flags  out  4  {N,Z,C,V}.

Behaviour:
- Opcodes:
  - 000x ADD/SUB (bit0=1 subtract: a+~b+1).
  - 0010 AND.
  - 0011 OR.
  - 0101 EOR.
  - 0100 MUL (low half only).
  - 1000 UMULL.
  - 1100 SMULL.
  - 1010 UMLAL, 1110 SMLAL (macro only).
  - Any other code: result=0, result_hi=0, flags=0000, completes as a single-cycle op.
- Reset: state IDLE; busy=0, done=0, result=0, result_hi=0, alu_flags=0000, counter=0. Reset mid-operation aborts immediately with no done pulse.
- FSM IDLE -> (start & single op) -> FIN.
- FSM IDLE -> (start & mul op) -> MUL.
- FSM MUL -> (counter==WIDTH-1) -> FIN.
- FSM FIN -> IDLE, always.
- On start, a, b, op and acc are latched; later input changes are ignored.
- busy=1 in MUL and FIN states. done=1 only in FIN.
- Latency, start asserted at cycle 0:
  - Single-cycle ops: done at cycle 1.
  - Multiply ops: done at cycle WIDTH+1.
- Throughput: new start accepted the cycle after done (IDLE). start while busy=1 is ignored, not queued.
- Signed multiply:
  - Latch |a| and |b|, iterate unsigned.
  - In the MUL->FIN transition, two's-complement negate the 2*WIDTH product if a[W-1]^b[W-1].
  - Special cases must be exact: most-negative x most-negative, and x0.
- Iteration: 2*WIDTH accumulator; each cycle add (multiplicand << i) when multiplier bit i=1. counter increments 0..WIDTH-1.
- Output timing: result, result_hi and alu_flags update only on entry to FIN and hold until the next FIN or reset.
- N flag: result[W-1] for single-width ops; result_hi[W-1] for long ops.
- Z flag: result==0 for single-width ops; {result_hi,result}==0 for long ops.
- C flag:
  - ADD: carry-out.
  - SUB: NOT borrow (1 when a>=b unsigned).
  - Logic and multiply ops: 0.
- V flag: signed overflow of ADD/SUB, computed as in the single-cycle ALU; 0 otherwise.
- Width rules: all sums are WIDTH+1 bits; the product is exactly 2*WIDTH bits; no truncation except MUL, which discards the high half (result_hi=0).

Optional Feature:
- Macro: ALU_MLAL_EN.
- Defined:
  - Opcodes 1010/1110 perform UMLAL/SMLAL: {result_hi,result} = product + {acc_hi,acc_lo} mod 2^(2W).
  - The accumulate is added in the FIN-entry cycle, after sign correction; latency is unchanged.
- Undefined:
  - 1010/1110 decode as undefined ops.
  - acc_lo/acc_hi are ignored.
  - No 2W adder is synthesised.

Decomposition:
- Package alu_mc_pkg:
  - Opcode localparams (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_EOR, OP_MUL, OP_UMULL, OP_SMULL, OP_UMLAL, OP_SMLAL).
  - FSM state enum (S_IDLE, S_MUL, S_FIN).
  - Flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- Sub-module alu_mc_mul_iter:
  - Iterative unsigned/signed shift-add core.
  - Ports: load, signed_mode, a, b -> product[2W], last.
  - Top level keeps the single-cycle datapath, flags and handshake.

Test Plan (WIDTH=32):
- ADD a=0xFFFFFFFF, b=1, start -> done at cycle 1, result=0, flags N0 Z1 C1 V0, busy low at cycle 2.
- SUB a=0x80000000, b=1 -> result=0x7FFFFFFF, flags N0 Z0 C1 V1; SUB a=1, b=2 -> 0xFFFFFFFF, flags N1 Z0 C0 V0.
- UMULL a=b=0xFFFFFFFF -> done exactly at cycle 33, {hi,lo}=0xFFFFFFFE_00000001, flags N1 Z0 C0 V0. Toggle a/b/start mid-operation: no effect.
- SMULL a=0x80000000, b=0x80000000 -> 0x40000000_00000000. SMULL a=-3, b=7 -> 0xFFFFFFFF_FFFFFFEB, N=1. SMULL a=0, b=-1 -> all zero, Z=1.
- Assert reset at cycle 10 of a MUL -> no done pulse; next cycle busy=0 and all outputs 0. Subsequent ADD 2+3 -> 5 at cycle 1.
- ALU_MLAL_EN: UMLAL a=2, b=3, acc={1,0xFFFFFFFF} -> {2,5} at cycle 33. Without the macro the same opcode -> result 0, flags 0000, done at cycle 1.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcodes, FSM states, flag bit indices and decode helpers for alu_mc.
// Optional macro ALU_MLAL_EN adds the UMLAL/SMLAL multiply-accumulate opcodes.
package alu_mc_pkg;
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_EOR   = 4'b0101;
    localparam logic [3:0] OP_MUL   = 4'b0100;
    localparam logic [3:0] OP_UMULL = 4'b1000;
    localparam logic [3:0] OP_SMULL = 4'b1100;
    localparam logic [3:0] OP_UMLAL = 4'b1010;
    localparam logic [3:0] OP_SMLAL = 4'b1110;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIN} state_t;

    function automatic logic is_mla_op(input logic [3:0] op);
        return op == OP_UMLAL || op == OP_SMLAL;
    endfunction

    function automatic logic is_mul_op(input logic [3:0] op);
`ifdef ALU_MLAL_EN
        return op == OP_MUL || op == OP_UMULL || op == OP_SMULL || is_mla_op(op);
`else
        return op == OP_MUL || op == OP_UMULL || op == OP_SMULL;
`endif
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return op == OP_SMULL || op == OP_SMLAL;
    endfunction
endpackage

// File: rtl/alu_mc_mul_iter.sv
// alu_mc_mul_iter: iterative shift-add multiplier, one multiplier bit per cycle.
// Ports: clk, reset (sync, active-high), load (latch operands and start),
// signed_mode (treat a/b as two's complement), a, b -> product (2*WIDTH,
// valid in the cycle last=1), last (final iteration in progress).
module alu_mc_mul_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);
    logic               r_run;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_step;

    // Magnitudes; the most-negative value maps to 2^(W-1), which is exact as unsigned.
    assign w_abs_a = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign w_abs_b = (signed_mode && b[WIDTH-1]) ? -b : b;
    assign w_step  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign last    = r_run && r_cnt == CNT_W'(WIDTH - 1);
    // Sign correction folds into the final iteration so the caller latches it on FIN entry.
    assign product = r_neg ? -w_step : w_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_run    <= 1'b0;
            r_neg    <= 1'b0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (load) begin
            r_run    <= 1'b1;
            r_neg    <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
            r_acc    <= '0;
            r_mplier <= w_abs_b;
            r_cnt    <= '0;
        end else if (r_run) begin
            r_acc    <= w_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= last ? '0 : r_cnt + 1'b1;
            r_run    <= !last;
        end
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multicycle ALU with start/done handshake and registered NZCV flags.
// Ports: clk, reset (sync, active-high), start, alu_control[3:0], a, b,
// acc_lo, acc_hi (accumulator, ALU_MLAL_EN only) -> busy, done (1-cycle pulse),
// result, result_hi (long products), alu_flags {N,Z,C,V}.
// Macro ALU_MLAL_EN enables UMLAL/SMLAL; otherwise those codes are undefined ops.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] acc_hi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       alu_flags
);
    state_t             r_state;
    logic [3:0]         r_op;
    logic               w_load;
    logic               w_last;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_full;
    logic               w_sub;
    logic               w_addsub;
    logic               w_logic;
    logic [WIDTH-1:0]   w_bx;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_s_res;
    logic [3:0]         w_s_flags;
    logic               w_long;
    logic [WIDTH-1:0]   w_m_hi;
    logic [3:0]         w_m_flags;

    assign w_load = r_state == S_IDLE && start && is_mul_op(alu_control);

    alu_mc_mul_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
        .clk         (clk),
        .reset       (reset),
        .load        (w_load),
        .signed_mode (is_signed_op(alu_control)),
        .a           (a),
        .b           (b),
        .product     (w_prod),
        .last        (w_last)
    );

    // Single-cycle datapath works straight off the inputs in the start cycle.
    assign w_sub    = alu_control[0];
    assign w_addsub = alu_control[3:1] == 3'b000;
    assign w_logic  = alu_control == OP_AND || alu_control == OP_OR || alu_control == OP_EOR;
    assign w_bx     = w_sub ? ~b : b;
    assign w_sum    = {1'b0, a} + {1'b0, w_bx} + (WIDTH + 1)'(w_sub);
    assign w_s_res  = w_addsub ? w_sum[WIDTH-1:0] :
                      alu_control == OP_AND ? a & b :
                      alu_control == OP_OR  ? a | b :
                      alu_control == OP_EOR ? a ^ b : '0;

    always_comb begin
        w_s_flags         = '0;
        w_s_flags[FLAG_N] = (w_addsub || w_logic) && w_s_res[WIDTH-1];
        w_s_flags[FLAG_Z] = (w_addsub || w_logic) && w_s_res == '0;
        w_s_flags[FLAG_C] = w_addsub && w_sum[WIDTH];
        w_s_flags[FLAG_V] = w_addsub && a[WIDTH-1] == w_bx[WIDTH-1] && w_sum[WIDTH-1] != a[WIDTH-1];
    end

`ifdef ALU_MLAL_EN
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_acc_hi;
    assign w_full = w_prod + (is_mla_op(r_op) ? {r_acc_hi, r_acc_lo} : '0);
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_lo <= '0;
            r_acc_hi <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_acc_lo <= acc_lo;
            r_acc_hi <= acc_hi;
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{acc_lo, acc_hi};
    assign w_full   = w_prod;
`endif

    // MUL keeps only the low half; every other multiply is a long op.
    assign w_long = r_op != OP_MUL;
    assign w_m_hi = w_long ? w_full[2*WIDTH-1:WIDTH] : '0;

    always_comb begin
        w_m_flags         = '0;
        w_m_flags[FLAG_N] = w_long ? w_full[2*WIDTH-1] : w_full[WIDTH-1];
        w_m_flags[FLAG_Z] = w_long ? w_full == '0 : w_full[WIDTH-1:0] == '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            alu_flags <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_op <= alu_control;
                    busy <= 1'b1;
                    if (is_mul_op(alu_control)) begin
                        r_state <= S_MUL;
                    end else begin
                        r_state   <= S_FIN;
                        done      <= 1'b1;
                        result    <= w_s_res;
                        result_hi <= '0;
                        alu_flags <= w_s_flags;
                    end
                end
                S_MUL: if (w_last) begin
                    r_state   <= S_FIN;
                    done      <= 1'b1;
                    result    <= w_full[WIDTH-1:0];
                    result_hi <= w_m_hi;
                    alu_flags <= w_m_flags;
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc (WIDTH=32); honours ALU_MLAL_EN.
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  alu_control;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] acc_lo;
    logic [31:0] acc_hi;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic [3:0]  alu_flags;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic [3:0]  fl;
        int          lat;
    } exp_t;

    typedef struct {
        string       nm;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] al;
        logic [31:0] ah;
        logic [31:0] res;
        logic [31:0] hi;
        logic [3:0]  fl;
        int          lat;
        bit          tog;
    } vec_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .alu_control (alu_control),
        .a           (a),
        .b           (b),
        .acc_lo      (acc_lo),
        .acc_hi      (acc_hi),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .result_hi   (result_hi),
        .alu_flags   (alu_flags)
    );

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] al, input logic [31:0] ah);
        exp_t        e;
        logic [32:0] s;
        logic [63:0] p;
        bit          long_op;
        bit          valid;
        e = '{32'h0, 32'h0, 4'h0, 1};
        p = '0;
        long_op = 0;
        valid = 1;
        case (op)
            4'b0000: begin
                s = {1'b0, x} + {1'b0, y};
                e.res = s[31:0];
                e.fl[1] = s[32];
                e.fl[0] = (x[31] == y[31]) && (e.res[31] != x[31]);
            end
            4'b0001: begin
                e.res = x - y;
                e.fl[1] = x >= y;
                e.fl[0] = (x[31] != y[31]) && (e.res[31] != x[31]);
            end
            4'b0010: e.res = x & y;
            4'b0011: e.res = x | y;
            4'b0101: e.res = x ^ y;
            4'b0100: begin e.res = x * y; e.lat = 33; end
            4'b1000: begin p = {32'h0, x} * {32'h0, y}; long_op = 1; end
            4'b1100: begin p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); long_op = 1; end
`ifdef ALU_MLAL_EN
            4'b1010: begin p = {32'h0, x} * {32'h0, y} + {ah, al}; long_op = 1; end
            4'b1110: begin p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}) + {ah, al}; long_op = 1; end
`endif
            default: valid = 0;
        endcase
        if (long_op) begin
            e.res = p[31:0];
            e.hi = p[63:32];
            e.fl[3] = p[63];
            e.fl[2] = p == 64'h0;
            e.lat = 33;
        end else if (valid) begin
            e.fl[3] = e.res[31];
            e.fl[2] = e.res == 32'h0;
        end
        return e;
    endfunction

    task automatic start_op(input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib,
                            input logic [31:0] al, input logic [31:0] ah);
        alu_control = op;
        a = ia;
        b = ib;
        acc_lo = al;
        acc_hi = ah;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit tog, output int lat, output logic [31:0] r, output logic [31:0] rh,
                             output logic [3:0] f, output logic bz, output logic da, output logic ba);
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            if (tog) begin
                a = $urandom;
                b = $urandom;
                alu_control = 4'($urandom);
                start = 1'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        r = result;
        rh = result_hi;
        f = alu_flags;
        bz = busy;
        @(posedge clk);
        #1;
        da = done;
        ba = busy;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        alu_control = 4'h0;
        a = '0;
        b = '0;
        acc_lo = '0;
        acc_hi = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 2;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_handshake: busy=%b done=%b, expected 0 0", busy, done);
        end
        if ({result, result_hi, alu_flags} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: result=%h hi=%h flags=%b, expected zeros", result, result_hi, alu_flags);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vectors(input vec_t v[$]);
        exp_t        e;
        int          lat;
        logic [31:0] r;
        logic [31:0] rh;
        logic [3:0]  f;
        logic        bz;
        logic        da;
        logic        ba;
        foreach (v[i]) begin
            q.push_back('{v[i].res, v[i].hi, v[i].fl, v[i].lat});
            start_op(v[i].op, v[i].a, v[i].b, v[i].al, v[i].ah);
            wait_done(v[i].tog, lat, r, rh, f, bz, da, ba);
            e = q.pop_front();
            n_checks += 5;
            if (r !== e.res) begin n_fail++; $display("FAIL %s result: got %h expected %h", v[i].nm, r, e.res); end
            if (rh !== e.hi) begin n_fail++; $display("FAIL %s result_hi: got %h expected %h", v[i].nm, rh, e.hi); end
            if (f !== e.fl) begin n_fail++; $display("FAIL %s flags: got %b expected %b", v[i].nm, f, e.fl); end
            if (lat !== e.lat) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", v[i].nm, lat, e.lat); end
            if ({bz, da, ba} !== 3'b100) begin
                n_fail++;
                $display("FAIL %s handshake: busy@done=%b done_next=%b busy_next=%b expected 1 0 0", v[i].nm, bz, da, ba);
            end
        end
    endtask

    task automatic test_single_cycle;
        vec_t v[$];
        v.push_back('{"add_wrap", 4'b0000, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0110, 1, 1'b0});
        v.push_back('{"add_ovf", 4'b0000, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 32'h80000000, 32'h0, 4'b1001, 1, 1'b0});
        v.push_back('{"sub_ovf", 4'b0001, 32'h80000000, 32'h1, 32'h0, 32'h0, 32'h7FFFFFFF, 32'h0, 4'b0011, 1, 1'b0});
        v.push_back('{"sub_borrow", 4'b0001, 32'h1, 32'h2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 4'b1000, 1, 1'b0});
        v.push_back('{"and", 4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 32'h0, 32'h00F000F0, 32'h0, 4'b0000, 1, 1'b0});
        v.push_back('{"or", 4'b0011, 32'h80000000, 32'h1, 32'h0, 32'h0, 32'h80000001, 32'h0, 4'b1000, 1, 1'b0});
        v.push_back('{"eor_zero", 4'b0101, 32'h12345678, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0100, 1, 1'b0});
        v.push_back('{"undef", 4'b0111, 32'h5, 32'h5, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 1, 1'b0});
        run_vectors(v);
    endtask

    task automatic test_multiply;
        vec_t v[$];
        v.push_back('{"umull_max", 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFE, 4'b1000, 33, 1'b1});
        v.push_back('{"smull_minmin", 4'b1100, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h40000000, 4'b0000, 33, 1'b0});
        v.push_back('{"smull_neg", 4'b1100, 32'hFFFFFFFD, 32'h7, 32'h0, 32'h0, 32'hFFFFFFEB, 32'hFFFFFFFF, 4'b1000, 33, 1'b1});
        v.push_back('{"smull_zero", 4'b1100, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0100, 33, 1'b0});
        v.push_back('{"mul_low", 4'b0100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h1, 32'h0, 4'b0000, 33, 1'b0});
        v.push_back('{"mul_trunc", 4'b0100, 32'h00010000, 32'h00010000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0100, 33, 1'b0});
`ifdef ALU_MLAL_EN
        v.push_back('{"umlal", 4'b1010, 32'h2, 32'h3, 32'hFFFFFFFF, 32'h1, 32'h5, 32'h2, 4'b0000, 33, 1'b0});
        v.push_back('{"smlal", 4'b1110, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 4'b0100, 33, 1'b0});
`else
        v.push_back('{"umlal_undef", 4'b1010, 32'h2, 32'h3, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 4'b0000, 1, 1'b0});
`endif
        run_vectors(v);
    endtask

    task automatic test_reset_mid;
        exp_t        e;
        int          lat;
        int          seen;
        logic [31:0] r;
        logic [31:0] rh;
        logic [3:0]  f;
        logic        bz;
        logic        da;
        logic        ba;
        start_op(4'b0000, 32'h10, 32'h20, 32'h0, 32'h0);
        wait_done(1'b0, lat, r, rh, f, bz, da, ba);
        start_op(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks += 2;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_handshake: busy=%b done=%b, expected 0 0", busy, done);
        end
        if ({result, result_hi, alu_flags} !== 68'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: result=%h hi=%h flags=%b, expected zeros", result, result_hi, alu_flags);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midreset_no_done: %0d active cycles after reset, expected 0", seen);
        end
        q.push_back(model(4'b0000, 32'd2, 32'd3, 32'h0, 32'h0));
        start_op(4'b0000, 32'd2, 32'd3, 32'h0, 32'h0);
        wait_done(1'b0, lat, r, rh, f, bz, da, ba);
        e = q.pop_front();
        n_checks += 2;
        if (r !== e.res || f !== e.fl) begin
            n_fail++;
            $display("FAIL post_reset_add: got %h/%b expected %h/%b", r, f, e.res, e.fl);
        end
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL post_reset_latency: got %0d expected 1", lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  ops[12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0100,
                                 4'b1000, 4'b1100, 4'b1010, 4'b1110, 4'b0111, 4'b1111};
        logic [31:0] corner[4] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        vec_t        v[$];
        exp_t        e;
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] al;
        logic [31:0] ah;
        for (int i = 0; i < 24; i++) begin
            op = ops[$urandom_range(0, 11)];
            x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 32'($urandom);
            y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 32'($urandom);
            al = $urandom;
            ah = $urandom;
            e = model(op, x, y, al, ah);
            v.push_back('{"b2b", op, x, y, al, ah, e.res, e.hi, e.fl, e.lat, 1'b0});
        end
        run_vectors(v);
    endtask

    initial begin
        test_reset;
        test_single_cycle;
        test_multiply;
        test_reset_mid;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
